// File: rtl/writeback_scoreboard.sv
// rtl/writeback_scoreboard.sv - writeback stage: load/ALU arbitration, load formatting, register busy scoreboard
module writeback_scoreboard #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  logic                      i_Issue_Valid,
  input  logic                      i_Issue_Writes,
  input  logic [REG_ADDR_WIDTH-1:0] i_Issue_Rd,
  input  logic [REG_ADDR_WIDTH-1:0] i_Issue_Rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_Issue_Rs2,
  output logic                      o_Issue_Stall,
  input  logic                      i_Alu_Valid,
  output logic                      o_Alu_Ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_Alu_Rd,
  input  logic [XLEN-1:0]           i_Alu_Data,
  input  logic                      i_Load_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_Load_Rd,
  input  logic [XLEN-1:0]           i_Load_Data,
  input  logic [2:0]                i_Load_Funct3,
  input  logic [1:0]                i_Load_Addr_Low,
  output logic                      o_Write_Enable,
  output logic [REG_ADDR_WIDTH-1:0] o_Write_Addr,
  output logic [XLEN-1:0]           o_Write_Data,
  output logic                      o_Load_Fault,
  output logic                      o_Idle
);
  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

  logic [NUM_REGS-1:0]       busy_q, busy_d;
  logic                      pipe_valid_q;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [XLEN-1:0]           ld_value;
  logic                      ld_fault;
  logic                      alu_accept, issue_set;
  logic                      res_valid, res_fault;
  logic [REG_ADDR_WIDTH-1:0] res_rd;
  logic [XLEN-1:0]           res_data;

  always_comb begin
    ld_value = '0;
    ld_fault = 1'b0;
    unique case (i_Load_Addr_Low)
      2'd0:    ld_byte = i_Load_Data[7:0];
      2'd1:    ld_byte = i_Load_Data[15:8];
      2'd2:    ld_byte = i_Load_Data[23:16];
      default: ld_byte = i_Load_Data[31:24];
    endcase
    ld_half = i_Load_Addr_Low[1] ? i_Load_Data[31:16] : i_Load_Data[15:0];
    case (i_Load_Funct3)
      3'b000:  ld_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001: begin
        ld_value = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_fault = i_Load_Addr_Low[0];
      end
      3'b010: begin
        ld_value = i_Load_Data;
        ld_fault = (i_Load_Addr_Low != 2'd0);
      end
      3'b100:  ld_value = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101: begin
        ld_value = {{(XLEN-16){1'b0}}, ld_half};
        ld_fault = i_Load_Addr_Low[0];
      end
      default: ld_fault = 1'b1;
    endcase
  end

  // Loads cannot be back-pressured, so they always win the single write slot
  assign o_Alu_Ready = ~i_Load_Valid;
  assign alu_accept  = i_Alu_Valid & ~i_Load_Valid;
  assign res_valid   = i_Load_Valid | alu_accept;
  assign res_rd      = i_Load_Valid ? i_Load_Rd : i_Alu_Rd;
  assign res_data    = i_Load_Valid ? ld_value : i_Alu_Data;
  assign res_fault   = i_Load_Valid & ld_fault;

  assign o_Issue_Stall = i_Issue_Valid & (busy_q[i_Issue_Rs1] | busy_q[i_Issue_Rs2] |
                                          (i_Issue_Writes & busy_q[i_Issue_Rd]));
  assign issue_set     = i_Issue_Valid & i_Issue_Writes & ~o_Issue_Stall & (i_Issue_Rd != '0);
  assign o_Idle        = (busy_q == '0) & ~pipe_valid_q;

  // Retire clears first so a same-cycle issue to that register keeps it busy
  always_comb begin
    busy_d = busy_q;
    if (pipe_valid_q) busy_d[o_Write_Addr] = 1'b0;
    if (issue_set) busy_d[i_Issue_Rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      busy_q         <= '0;
      pipe_valid_q   <= 1'b0;
      o_Write_Enable <= 1'b0;
      o_Write_Addr   <= '0;
      o_Write_Data   <= '0;
      o_Load_Fault   <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      pipe_valid_q   <= res_valid;
      o_Write_Enable <= res_valid & ~res_fault & (res_rd != '0);
      o_Load_Fault   <= res_fault;
      if (res_valid) begin
        o_Write_Addr <= res_rd;
        o_Write_Data <= res_data;
      end
    end
  end
endmodule

// File: tb/tb_writeback_scoreboard.sv
// tb/tb_writeback_scoreboard.sv - scoreboard bench for writeback_scoreboard with a queue-based reference model
module tb_writeback_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic issue_valid, issue_writes, issue_stall;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  logic alu_valid, alu_ready;
  logic [4:0] alu_rd;
  logic [31:0] alu_data;
  logic load_valid;
  logic [4:0] load_rd;
  logic [31:0] load_data;
  logic [2:0] load_funct3;
  logic [1:0] load_addr_low;
  logic wr_en, load_fault, idle;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;

  writeback_scoreboard #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .i_Clock(clk), .i_Reset_N(rst_n),
    .i_Issue_Valid(issue_valid), .i_Issue_Writes(issue_writes), .i_Issue_Rd(issue_rd),
    .i_Issue_Rs1(issue_rs1), .i_Issue_Rs2(issue_rs2), .o_Issue_Stall(issue_stall),
    .i_Alu_Valid(alu_valid), .o_Alu_Ready(alu_ready), .i_Alu_Rd(alu_rd), .i_Alu_Data(alu_data),
    .i_Load_Valid(load_valid), .i_Load_Rd(load_rd), .i_Load_Data(load_data),
    .i_Load_Funct3(load_funct3), .i_Load_Addr_Low(load_addr_low),
    .o_Write_Enable(wr_en), .o_Write_Addr(wr_addr), .o_Write_Data(wr_data),
    .o_Load_Fault(load_fault), .o_Idle(idle)
  );

  typedef struct {
    int         cyc;
    bit         we;
    bit         fault;
    logic [4:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pend[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  bit issued[32];
  bit accepted[32];
  int acc_cyc[32];
  int last_acc = -10;
  bit alu_blocked = 1'b0;

  bit          p_iv, p_iw, p_av, p_lv;
  logic [4:0]  p_rd, p_rs1, p_rs2, p_ard, p_lrd;
  logic [31:0] p_adata, p_ldata;
  logic [2:0]  p_lf3;
  logic [1:0]  p_la;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit mbusy(input int r, input int c);
    return (r != 0) && issued[r] && (!accepted[r] || c < acc_cyc[r] + 2);
  endfunction

  function automatic void ref_load(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] a,
                                   output bit flt, output logic [31:0] v);
    logic [31:0] w;
    w = d >> (8 * a);
    flt = 1'b0;
    v = 32'd0;
    case (f3)
      3'd0: v = {{24{w[7]}}, w[7:0]};
      3'd1: begin flt = a[0]; v = {{16{w[15]}}, w[15:0]}; end
      3'd2: begin flt = (a != 2'd0); v = d; end
      3'd4: v = {24'd0, w[7:0]};
      3'd5: begin flt = a[0]; v = {16'd0, w[15:0]}; end
      default: flt = 1'b1;
    endcase
  endfunction

  function automatic void drop_pend(input int r);
    foreach (pend[i]) if (pend[i] == r) begin pend.delete(i); return; end
  endfunction

  function automatic void retire_model(input int r, input int c, input bit we, input bit flt, input logic [31:0] d);
    exp_t e;
    if (r != 0) begin accepted[r] = 1'b1; acc_cyc[r] = c; end
    last_acc = c;
    drop_pend(r);
    if (we || flt) begin
      e.cyc = c + 1; e.we = we; e.fault = flt; e.addr = r[4:0]; e.data = d;
      exp_q.push_back(e);
    end
  endfunction

  task automatic clear_plan();
    p_iv = 0; p_iw = 0; p_rd = 0; p_rs1 = 0; p_rs2 = 0;
    p_av = 0; p_ard = 0; p_adata = 0;
    p_lv = 0; p_lrd = 0; p_ldata = 0; p_lf3 = 0; p_la = 0;
  endtask

  task automatic do_cycle();
    int c;
    bit exp_stall, exp_idle, flt;
    logic [31:0] v;
    @(posedge clk);
    #1;
    c = cyc;
    issue_valid = p_iv; issue_writes = p_iw; issue_rd = p_rd; issue_rs1 = p_rs1; issue_rs2 = p_rs2;
    alu_valid = p_av; alu_rd = p_ard; alu_data = p_adata;
    load_valid = p_lv; load_rd = p_lrd; load_data = p_ldata; load_funct3 = p_lf3; load_addr_low = p_la;
    exp_stall = p_iv && (mbusy(p_rs1, c) || mbusy(p_rs2, c) || (p_iw && mbusy(p_rd, c)));
    exp_idle = (last_acc != c - 1);
    for (int r = 0; r < 32; r++) if (mbusy(r, c)) exp_idle = 1'b0;
    #1;
    check("issue_stall", issue_stall, exp_stall);
    check("alu_ready", alu_ready, !p_lv);
    check("idle", idle, exp_idle);
    if (p_lv) begin
      ref_load(p_ldata, p_lf3, p_la, flt, v);
      retire_model(p_lrd, c, !flt && p_lrd != 0, flt, v);
    end else if (p_av) begin
      retire_model(p_ard, c, p_ard != 0, 1'b0, p_adata);
    end
    alu_blocked = p_av && p_lv;
    if (p_iv && !exp_stall && p_iw && p_rd != 0) begin
      issued[p_rd] = 1'b1;
      accepted[p_rd] = 1'b0;
      pend.push_back(p_rd);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        me = exp_q.pop_front();
        check("write_enable", wr_en, me.we);
        check("load_fault", load_fault, me.fault);
        if (me.we) begin
          check("write_addr", wr_addr, me.addr);
          check("write_data", wr_data, me.data);
        end
      end else begin
        check("no_output", {wr_en, load_fault}, 0);
      end
    end
  end

  initial begin
    int idx;
    clear_plan();
    rst_n = 0;
    issue_valid = 0; issue_writes = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    load_valid = 0; load_rd = 0; load_data = 0; load_funct3 = 0; load_addr_low = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_write_enable", wr_en, 0);
    check("rst_write_addr", wr_addr, 0);
    check("rst_write_data", wr_data, 0);
    check("rst_load_fault", load_fault, 0);
    check("rst_idle", idle, 1);
    check("rst_alu_ready", alu_ready, 1);
    rst_n = 1;
    mon_en = 1;

    // ALU path and RAW stall on rd=5
    clear_plan(); p_iv = 1; p_iw = 1; p_rd = 5; do_cycle();
    clear_plan(); p_av = 1; p_ard = 5; p_adata = 32'hDEADBEEF; p_iv = 1; p_rs1 = 5; do_cycle();
    repeat (3) begin clear_plan(); p_iv = 1; p_rs1 = 5; do_cycle(); end

    // Load/ALU collision
    clear_plan(); p_iv = 1; p_iw = 1; p_rd = 3; do_cycle();
    clear_plan(); p_iv = 1; p_iw = 1; p_rd = 4; do_cycle();
    clear_plan(); p_lv = 1; p_lrd = 3; p_ldata = 32'h12345678; p_lf3 = 3'd2;
    p_av = 1; p_ard = 4; p_adata = 32'hCAFEF00D; do_cycle();
    p_lv = 0; do_cycle();
    clear_plan(); repeat (3) do_cycle();

    // Load formatting on 0x8070F0A5
    for (int r = 10; r < 14; r++) begin clear_plan(); p_iv = 1; p_iw = 1; p_rd = r[4:0]; do_cycle(); end
    clear_plan(); p_lv = 1; p_ldata = 32'h8070F0A5;
    p_lrd = 10; p_lf3 = 3'd0; p_la = 2'd1; do_cycle();
    p_lrd = 11; p_lf3 = 3'd4; p_la = 2'd3; do_cycle();
    p_lrd = 12; p_lf3 = 3'd1; p_la = 2'd2; do_cycle();
    p_lrd = 13; p_lf3 = 3'd5; p_la = 2'd0; do_cycle();

    // Misaligned LW fault on rd=7, then x0 issue and result
    clear_plan(); p_iv = 1; p_iw = 1; p_rd = 7; do_cycle();
    clear_plan(); p_lv = 1; p_lrd = 7; p_ldata = 32'h55AA55AA; p_lf3 = 3'd2; p_la = 2'd2; do_cycle();
    clear_plan(); p_iv = 1; p_iw = 1; p_rd = 0; p_av = 1; p_ard = 0; p_adata = 32'h11111111; do_cycle();
    clear_plan(); p_iv = 1; p_rs1 = 7; p_rs2 = 7; do_cycle();
    clear_plan(); repeat (3) do_cycle();

    // Randomized traffic
    repeat (3000) begin
      p_iv = $urandom_range(0, 1); p_iw = $urandom_range(0, 1);
      p_rd = 5'($urandom_range(0, 7)); p_rs1 = 5'($urandom_range(0, 7)); p_rs2 = 5'($urandom_range(0, 7));
      if (!alu_blocked) begin
        p_av = 0;
        if (pend.size() != 0 && $urandom_range(0, 2) == 0) begin
          p_av = 1; p_ard = 5'(pend[$urandom_range(0, pend.size() - 1)]); p_adata = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
          p_av = 1; p_ard = 0; p_adata = $urandom;
        end
      end
      p_lv = 0;
      if (pend.size() != 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, pend.size() - 1);
        if (!(p_av && pend[idx] == int'(p_ard))) begin
          p_lv = 1; p_lrd = 5'(pend[idx]); p_ldata = $urandom;
          p_lf3 = 3'($urandom_range(0, 7)); p_la = 2'($urandom_range(0, 3));
        end
      end
      do_cycle();
    end

    // Drain outstanding results
    p_iv = 0; p_lv = 0;
    for (int n = 0; n < 64 && (pend.size() != 0 || alu_blocked); n++) begin
      if (!alu_blocked) begin p_av = 1; p_ard = 5'(pend[0]); p_adata = $urandom; end
      do_cycle();
    end
    clear_plan(); repeat (4) do_cycle();
    check("final_idle", idle, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
